demux_scheduler: RTL and testbench
==================================

Name: demux_scheduler

Overview:
- Controller that sequences a 1-to-4 demultiplexer datapath.
- Accepts data words on a valid/ready input and holds each word.
- Chooses a destination channel: round-robin among ready channels, or the channel named with the word.
- Drives the demux select and enable for one transfer cycle per word. Sits between a single producer and four consumer channels.

Parameters:
- DATA_W, 8, width of data word routed through the demux.
- SAT_W, 8, width of per-channel delivery counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  scheduler can accept a word.
- in_data  input  DATA_W  word to route.
- in_dest  input  2  requested channel, used in directed mode.
- cfg_mode  input  1  0 = round-robin, 1 = directed; sampled at accept.
- out_ready  input  4  per-channel consumer ready.
- sel  output  2  demux select (S).
- en  output  1  demux enable (E).
- out_data  output  DATA_W  held word presented to demux input (I).
- out_valid  output  4  one-hot valid, equal to en ? (1<<sel) : 0.
- busy  output  1  high whenever state != IDLE.

Clock/reset decision: one clock; reset is asynchronous and active-low.

Behaviour:
- States: IDLE, ARB, SEND. Reset forces IDLE.
- Reset values: in_ready=1 after reset release (in_ready = state==IDLE), sel=0, en=0, out_data=0, out_valid=0, busy=0. Round-robin pointer rr_ptr=0. Held mode=0, held dest=0.
- IDLE: in_valid&in_ready at edge k -> capture in_data, in_dest and cfg_mode into hold registers; next state ARB.
- ARB, round-robin mode: search out_ready starting at rr_ptr, ascending modulo 4 (rr_ptr, rr_ptr+1, ..., wrap 3->0).
  - First ready channel c -> sel<=c, en<=1, state SEND.
  - None ready -> stay ARB, en=0.
- ARB, directed mode: if out_ready[dest] -> sel<=dest, en<=1, SEND. Otherwise stay ARB; no other channel is ever chosen.
- SEND: en=1, out_valid one-hot on sel for the full cycle.
  - out_ready[sel]=1 at the edge -> transfer completes. en<=0, state IDLE. In round-robin mode rr_ptr<=sel+1 mod 4; directed mode leaves rr_ptr unchanged.
  - out_ready[sel]=0 at the edge -> retract. en<=0, back to ARB; the word is kept and re-arbitrated.
- Latency: accept at edge k, earliest en=1 during cycle k+1..k+2, delivery at edge k+2. Minimum 3 cycles per word; in_ready low from edge k until edge after delivery.
- out_data equals the held word whenever en=1. It is unchanged in ARB and holds its last value in IDLE.
- sel changes only on the ARB->SEND edge. out_valid never has more than one bit set. en=0 outside SEND.
- Simultaneous readies: lowest index at or after rr_ptr wins.
- in_valid dropped while busy has no effect; cfg_mode and in_dest changes after accept are ignored.
- Reset mid-operation (any state): held word discarded, all outputs to reset values immediately (asynchronous), rr_ptr=0.

Optional Feature:
- Macro DEMUX_SCHED_STATS_EN.
- Defined:
  - Adds output stat_cnt, 4*SAT_W wide: four SAT_W-bit counters, channel c at bits [c*SAT_W +: SAT_W].
  - Channel c increments on each completed delivery to c and saturates at all-ones.
  - Adds input stat_clr (1 bit). stat_clr=1 zeroes all counters synchronously; it wins over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- Not defined: no stat ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset then round-robin, out_ready=4'b1111, send 0xA1,0xA2,0xA3,0xA4,0xA5 -> delivered on sel 0,1,2,3,0 respectively; each word 3 cycles apart; out_valid one-hot.
- Round-robin skip: rr_ptr=1, out_ready=4'b1001, send 0x55 -> sel=3, rr_ptr becomes 0; next word with out_ready=4'b1111 -> sel=0.
- Directed stall: cfg_mode=1, in_dest=2, out_ready=4'b1011 for 5 cycles then 4'b0100 -> state stays ARB, en=0 for 5 cycles; then en=1 with sel=2, delivers 0x3C; rr_ptr unchanged.
- Retract: SEND on sel=1 with out_ready[1] dropping in that cycle -> back to ARB, word kept. Re-sent to channel 2 if only out_ready[2]=1 (round-robin); in_ready stays 0 until delivery.
- Async reset during SEND (rst_n low mid-cycle) -> en, out_valid, busy go 0 immediately, in_ready=1 after release; the held word is never delivered.
- With DEMUX_SCHED_STATS_EN and SAT_W=2: 5 deliveries to channel 0 -> count 3 (saturated); stat_clr pulse -> 0.

Source files
------------

// File: rtl/demux_scheduler.sv
// Sequencer for a 1-to-4 demux: accepts one word, arbitrates a destination, drives sel/en for the transfer.
// Optional per-channel delivery counters are enabled with `define DEMUX_SCHED_STATS_EN.
module demux_scheduler #(
    parameter int DATA_W = 8,
    parameter int SAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              cfg_mode,
    input  logic [3:0]        out_ready,
    output logic [1:0]        sel,
    output logic              en,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_valid,
    output logic              busy
`ifdef DEMUX_SCHED_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [4*SAT_W-1:0] stat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SEND
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] hold_dest;
    logic       hold_mode;
    logic       arb_hit;
    logic [1:0] arb_ch;
    logic [1:0] scan_idx;
    logic       accept;
    logic       deliver;

    // Directed mode only ever considers the held destination; round-robin scans upward from rr_ptr.
    always_comb begin
        arb_hit  = 1'b0;
        arb_ch   = hold_dest;
        scan_idx = rr_ptr;
        if (hold_mode) begin
            arb_hit = out_ready[hold_dest];
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                scan_idx = rr_ptr + 2'(i);
                if (!arb_hit && out_ready[scan_idx]) begin
                    arb_hit = 1'b1;
                    arb_ch  = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (arb_hit) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready[sel]) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            hold_dest <= '0;
            hold_mode <= 1'b0;
            sel       <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_data  <= in_data;
                hold_dest <= in_dest;
                hold_mode <= cfg_mode;
            end
            if (state == ARB && arb_hit) begin
                sel <= arb_ch;
            end
            if (deliver && !hold_mode) begin
                rr_ptr <= sel + 2'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign en        = (state == SEND);
    assign out_valid = en ? (4'b0001 << sel) : '0;

`ifdef DEMUX_SCHED_STATS_EN
    logic [SAT_W-1:0] cnt [4];

    for (genvar c = 0; c < 4; c++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[c] <= '0;
            end else if (stat_clr) begin
                cnt[c] <= '0;
            end else if (deliver && sel == 2'(c) && cnt[c] != '1) begin
                cnt[c] <= cnt[c] + 1'b1;
            end
        end
        assign stat_cnt[c*SAT_W +: SAT_W] = cnt[c];
    end
`else
    if (SAT_W < 1) begin : g_sat_unused
    end
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Scoreboard bench for demux_scheduler: driver pushes expected (channel, word) pairs from a
// transaction-level round-robin model; a negedge monitor pops and compares on each delivery.
module tb_demux_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic        cfg_mode;
    logic [3:0]  out_ready;
    logic [1:0]  sel;
    logic        en;
    logic [7:0]  out_data;
    logic [3:0]  out_valid;
    logic        busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic        stat_clr;
    logic [7:0]  stat_cnt;
`endif

    always #5 clk = ~clk;

    demux_scheduler #(.DATA_W(8), .SAT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .cfg_mode  (cfg_mode),
        .out_ready (out_ready),
        .sel       (sel),
        .en        (en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef DEMUX_SCHED_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [9:0] exp_q[$];
    logic [1:0] m_rr     = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arbitration: directed goes to dest; round-robin takes the first ready channel
    // at or after the model pointer, and the pointer moves past the winner.
    function automatic logic [1:0] predict(input logic m, input logic [1:0] d, input logic [3:0] rdy);
        int c;
        if (m) return d;
        for (int i = 0; i < 4; i++) begin
            c = (int'(m_rr) + i) % 4;
            if (rdy[c]) begin
                m_rr = 2'((c + 1) % 4);
                return 2'(c);
            end
        end
        return m_rr;
    endfunction

    task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic m,
                        input bit expect_delivery, input logic [1:0] ch, output int acc_cyc);
        if (expect_delivery) exp_q.push_back({ch, d});
        in_data  = d;
        in_dest  = dst;
        cfg_mode = m;
        in_valid = 1'b1;
        acc_cyc  = -1;
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            check(1'b0, "accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_dest  = 2'($urandom);
        cfg_mode = 1'($urandom);
        in_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) check(1'b0, "idle_timeout", 0, 1);
    endtask

    task automatic wait_en();
        for (int i = 0; i < 200 && !en; i++) begin
            @(posedge clk); #1;
        end
        if (!en) check(1'b0, "en_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n === 1'b1) begin
            check($countones(out_valid) <= 1, "out_valid_onehot", out_valid, 0);
            check(out_valid == (en ? (4'b0001 << sel) : 4'b0000), "out_valid_vs_sel", out_valid, sel);
            check(busy == !in_ready, "busy_vs_in_ready", busy, !in_ready);
            if (en && out_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_delivery", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(sel == e[9:8], "deliver_channel", sel, e[9:8]);
                    check(out_data == e[7:0], "deliver_data", out_data, e[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         acc, prev;
        logic [1:0] ch, dst;
        logic [3:0] rdy;
        logic       m;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; cfg_mode = 1'b0; out_ready = '0;
`ifdef DEMUX_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        check(sel == 2'd0, "reset_sel", sel, 0);
        check(en == 1'b0, "reset_en", en, 0);
        check(out_data == 8'd0, "reset_out_data", out_data, 0);
        check(out_valid == 4'd0, "reset_out_valid", out_valid, 0);
        check(busy == 1'b0, "reset_busy", busy, 0);
        @(posedge clk); #1;

        // Back-to-back round-robin with every consumer ready: one word per 3 cycles.
        out_ready = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            ch = predict(1'b0, 2'd0, out_ready);
            send(8'hA1 + 8'(i), 2'd0, 1'b0, 1'b1, ch, acc);
            if (i > 0) check(acc - prev == 3, "rr_spacing", acc - prev, 3);
            prev = acc;
        end
        wait_idle();

        out_ready = 4'b1001;
        ch = predict(1'b0, 2'd0, out_ready);
        send(8'h55, 2'd0, 1'b0, 1'b1, ch, acc);
        wait_idle();
        out_ready = 4'b1111;
        ch = predict(1'b0, 2'd0, out_ready);
        send(8'h56, 2'd0, 1'b0, 1'b1, ch, acc);
        wait_idle();

        // Directed stall: destination not ready for 5 cycles.
        out_ready = 4'b1011;
        ch = predict(1'b1, 2'd2, 4'b0100);
        send(8'h3C, 2'd2, 1'b1, 1'b1, ch, acc);
        for (int i = 0; i < 5; i++) begin
            check(en == 1'b0, "stall_en", en, 0);
            check(busy == 1'b1, "stall_busy", busy, 1);
            @(posedge clk); #1;
        end
        out_ready = 4'b0100;
        wait_idle();

        // Retract: consumer 1 drops ready during its SEND cycle; word re-routes to 2.
        out_ready = 4'b0010;
        ch = predict(1'b0, 2'd0, 4'b0100);
        send(8'h77, 2'd0, 1'b0, 1'b1, ch, acc);
        wait_en();
        check(sel == 2'd1, "retract_first_sel", sel, 1);
        out_ready = 4'b0100;
        @(posedge clk); #1;
        check(en == 1'b0, "retract_en", en, 0);
        check(in_ready == 1'b0, "retract_in_ready", in_ready, 0);
        wait_idle();
        out_ready = 4'b1111;
        ch = predict(1'b0, 2'd0, out_ready);
        send(8'h78, 2'd0, 1'b0, 1'b1, ch, acc);
        wait_idle();

        // Asynchronous reset mid-SEND: the held word must never be delivered.
        send(8'h99, 2'd0, 1'b0, 1'b0, 2'd0, acc);
        wait_en();
        #2 rst_n = 1'b0;
        #1;
        check(en == 1'b0, "areset_en", en, 0);
        check(out_valid == 4'd0, "areset_out_valid", out_valid, 0);
        check(busy == 1'b0, "areset_busy", busy, 0);
        m_rr = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check(in_ready == 1'b1, "areset_in_ready", in_ready, 1);
        check(out_data == 8'd0, "areset_out_data", out_data, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            wait_idle();
            m   = 1'($urandom);
            dst = 2'($urandom);
            rdy = 4'($urandom);
            if (rdy == 4'd0) rdy = 4'b0001 << ($urandom % 4);
            if (m) rdy[dst] = 1'b1;
            out_ready = rdy;
            ch = predict(m, dst, rdy);
            send(8'($urandom), dst, m, 1'b1, ch, acc);
        end
        wait_idle();

`ifdef DEMUX_SCHED_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        out_ready = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            ch = predict(1'b1, 2'd0, out_ready);
            send(8'hC0 + 8'(i), 2'd0, 1'b1, 1'b1, ch, acc);
        end
        wait_idle();
        check(stat_cnt[1:0] == 2'd3, "stat_saturate", stat_cnt[1:0], 3);
        check(stat_cnt[7:2] == 6'd0, "stat_other_channels", stat_cnt[7:2], 0);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check(stat_cnt == 8'd0, "stat_clear", stat_cnt, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
